// File: rtl/aux_cmd_engine.sv
// Host auxiliary-channel command initiator: fetches command words, runs register bursts, returns responses.
// Define AUX_CMD_CHECKSUM_EN to append an XOR trailer word to every command's response.
module aux_cmd_engine #(
    parameter int REG_RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        aux_read_req,
    output logic        aux_write_req,
    output logic [31:0] aux_data_write,
    input  logic [31:0] aux_data_read,
    output logic [16:0] aux_address,
    input  logic        aux_busy,
    output logic [15:0] reg_addr,
    output logic [31:0] reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [31:0] reg_rdata,
    output logic        cmd_done,
    output logic        cmd_error
);

    typedef enum logic [3:0] {
        IDLE, HDR_WAIT, DECODE, DAT_REQ, DAT_WAIT, REG_WR, ECHO, RD_REG,
        RD_WAIT, ACK, ERR, CSUM, TX_REQ, TX_WAIT, FIN
    } state_t;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

`ifdef AUX_CMD_CHECKSUM_EN
    localparam state_t POST_RESP = CSUM;
`else
    localparam state_t POST_RESP = FIN;
`endif

    state_t      state, state_n, ret, ret_n;
    logic [31:0] hdr, hdr_n;
    logic [7:0]  idx, idx_n;
    logic [2:0]  lat, lat_n;
    logic        err, err_n;
    logic        rd_req_n, wr_req_n;
    logic [31:0] dw_n, wdata_n;
    logic [15:0] addr_n;
    logic [7:0]  cnt;
    logic        last, cap, rd_done, wr_done;

    assign cnt         = hdr[23:16];
    assign last        = (idx + 8'd1) == cnt;
    assign cap         = (lat == 3'(REG_RD_LATENCY));
    // The registered request is high during its own cycle, so completion ignores that cycle.
    assign rd_done     = !aux_read_req && !aux_busy;
    assign wr_done     = !aux_write_req && !aux_busy;
    assign aux_address = '0;
    assign reg_we      = (state == REG_WR);
    assign reg_re      = (state == RD_REG);
    assign cmd_done    = (state == FIN);
    assign cmd_error   = (state == FIN) && err;

`ifdef AUX_CMD_CHECKSUM_EN
    logic [31:0] csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            csum <= '0;
        else if (state == IDLE)
            csum <= '0;
        else if (state == ECHO || state == ACK || state == ERR || (state == RD_WAIT && cap))
            csum <= csum ^ dw_n;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            ret            <= IDLE;
            hdr            <= '0;
            idx            <= '0;
            lat            <= '0;
            err            <= 1'b0;
            aux_read_req   <= 1'b0;
            aux_write_req  <= 1'b0;
            aux_data_write <= '0;
            reg_addr       <= '0;
            reg_wdata      <= '0;
        end else begin
            state          <= state_n;
            ret            <= ret_n;
            hdr            <= hdr_n;
            idx            <= idx_n;
            lat            <= lat_n;
            err            <= err_n;
            aux_read_req   <= rd_req_n;
            aux_write_req  <= wr_req_n;
            aux_data_write <= dw_n;
            reg_addr       <= addr_n;
            reg_wdata      <= wdata_n;
        end
    end

    always_comb begin
        state_n  = state;
        ret_n    = ret;
        hdr_n    = hdr;
        idx_n    = idx;
        lat_n    = lat;
        err_n    = err;
        rd_req_n = 1'b0;
        wr_req_n = 1'b0;
        dw_n     = aux_data_write;
        addr_n   = reg_addr;
        wdata_n  = reg_wdata;
        case (state)
            IDLE: begin
                idx_n = '0;
                lat_n = '0;
                err_n = 1'b0;
                if (!aux_busy) begin
                    rd_req_n = 1'b1;
                    state_n  = HDR_WAIT;
                end
            end
            HDR_WAIT: begin
                if (rd_done) begin
                    hdr_n   = aux_data_read;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                addr_n = hdr[15:0];
                if (cnt == 8'd0)
                    state_n = ERR;
                else if (hdr[31:24] == OP_WRITE)
                    state_n = DAT_REQ;
                else if (hdr[31:24] == OP_READ)
                    state_n = ECHO;
                else
                    state_n = ERR;
            end
            DAT_REQ: begin
                if (!aux_busy) begin
                    rd_req_n = 1'b1;
                    state_n  = DAT_WAIT;
                end
            end
            DAT_WAIT: begin
                if (rd_done) begin
                    wdata_n = aux_data_read;
                    state_n = REG_WR;
                end
            end
            REG_WR: begin
                idx_n   = idx + 8'd1;
                addr_n  = reg_addr + 16'd1;
                state_n = last ? ACK : DAT_REQ;
            end
            ECHO: begin
                dw_n    = {OP_READ, cnt, hdr[15:0]};
                ret_n   = RD_REG;
                state_n = TX_REQ;
            end
            RD_REG: begin
                lat_n   = 3'd1;
                state_n = RD_WAIT;
            end
            RD_WAIT: begin
                if (cap) begin
                    dw_n    = reg_rdata;
                    idx_n   = idx + 8'd1;
                    addr_n  = reg_addr + 16'd1;
                    ret_n   = last ? POST_RESP : RD_REG;
                    state_n = TX_REQ;
                end else begin
                    lat_n = lat + 3'd1;
                end
            end
            ACK: begin
                dw_n    = {8'hAC, cnt, hdr[15:0]};
                ret_n   = POST_RESP;
                state_n = TX_REQ;
            end
            ERR: begin
                dw_n    = {8'hEE, hdr[23:0]};
                err_n   = 1'b1;
                ret_n   = POST_RESP;
                state_n = TX_REQ;
            end
`ifdef AUX_CMD_CHECKSUM_EN
            CSUM: begin
                dw_n    = csum;
                ret_n   = FIN;
                state_n = TX_REQ;
            end
`endif
            TX_REQ: begin
                if (!aux_busy) begin
                    wr_req_n = 1'b1;
                    state_n  = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (wr_done)
                    state_n = ret;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_aux_cmd_engine.sv
// Directed bench for aux_cmd_engine with a behavioural host-link bridge and register bus.
`timescale 1ns/1ps
module tb_aux_cmd_engine;
    localparam int RD_LAT = 3;
    localparam int BR_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        aux_read_req, aux_write_req;
    logic [31:0] aux_data_write;
    logic [31:0] aux_data_read = '0;
    logic [16:0] aux_address;
    logic        aux_busy;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_we, reg_re;
    logic [31:0] reg_rdata = '0;
    logic        cmd_done, cmd_error;

    logic        pend = 1'b0;
    logic        hold = 1'b0;
    logic        in_flight = 1'b0;
    logic        is_rd = 1'b0;
    logic        busy_prev = 1'b0;
    logic        hold_prev = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] dw_req = '0;
    logic [31:0] rd_pipe [4] = '{default: '0};

    logic [31:0] host_q[$];
    logic [31:0] rx_q[$];
    logic [31:0] exp_q[$];
    logic [15:0] wa_q[$];
    logic [31:0] wd_q[$];

    int re_cnt = 0, done_cnt = 0, err_cnt = 0, err_alone = 0, req_cnt = 0;
    int both_cnt = 0, early_cnt = 0, overlap_cnt = 0, dw_change = 0, stall_req = 0;
    int n_chk = 0, n_pass = 0;
    int d0, re0, err0, r0, n;

    assign aux_busy = aux_read_req | aux_write_req | pend | hold;

    aux_cmd_engine #(.REG_RD_LATENCY(RD_LAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .aux_read_req  (aux_read_req),
        .aux_write_req (aux_write_req),
        .aux_data_write(aux_data_write),
        .aux_data_read (aux_data_read),
        .aux_address   (aux_address),
        .aux_busy      (aux_busy),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_we        (reg_we),
        .reg_re        (reg_re),
        .reg_rdata     (reg_rdata),
        .cmd_done      (cmd_done),
        .cmd_error     (cmd_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_val(input logic [15:0] a);
        return (a == 16'h0000) ? 32'h0000F0F0 : 32'h000000A0 + {16'h0000, a};
    endfunction

    // Bridge, register bus and protocol monitors all act on the falling edge.
    always @(negedge clk) begin
        if (reg_we) begin
            wa_q.push_back(reg_addr);
            wd_q.push_back(reg_wdata);
        end
        if (reg_re) re_cnt++;
        if (cmd_done) done_cnt++;
        if (cmd_error) err_cnt++;
        if (cmd_error && !cmd_done) err_alone++;
        reg_rdata = rd_pipe[RD_LAT-1];
        for (int i = 3; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
        rd_pipe[0] = reg_re ? reg_val(reg_addr) : 32'hDEADBEEF;
        if (reset) begin
            in_flight = 1'b0;
            pend      = 1'b0;
        end else if (aux_read_req || aux_write_req) begin
            req_cnt++;
            if (aux_read_req && aux_write_req) both_cnt++;
            if (busy_prev) early_cnt++;
            if (hold_prev) stall_req++;
            if (in_flight) overlap_cnt++;
            in_flight = 1'b1;
            pend      = 1'b1;
            is_rd     = aux_read_req;
            wait_cnt  = BR_LAT;
            dw_req    = aux_data_write;
        end else if (in_flight) begin
            if (wait_cnt > 1) begin
                wait_cnt--;
            end else if (!(is_rd && host_q.size() == 0)) begin
                in_flight = 1'b0;
                pend      = 1'b0;
                if (is_rd) begin
                    aux_data_read = host_q.pop_front();
                end else begin
                    rx_q.push_back(aux_data_write);
                    if (aux_data_write != dw_req) dw_change++;
                end
            end
        end
        busy_prev = aux_read_req | aux_write_req | pend | hold;
        hold_prev = hold;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic chk_rx(input string tag);
        chk({tag, "_nrx"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_rx%0d", tag, i),
                (i < rx_q.size()) ? {32'h0, rx_q[i]} : 64'hBAD0BAD0BAD0BAD0, exp_q[i]);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_ctrl"}, {aux_read_req, aux_write_req, reg_we, reg_re, cmd_done, cmd_error}, 0);
        chk({tag, "_dw"}, aux_data_write, 0);
        chk({tag, "_addr"}, {aux_address, reg_addr}, 0);
        chk({tag, "_wdata"}, reg_wdata, 0);
    endtask

    task automatic begin_cmd();
        rx_q.delete();
        wa_q.delete();
        wd_q.delete();
        exp_q.delete();
        d0   = done_cnt;
        re0  = re_cnt;
        err0 = err_cnt;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_cnt < d0 + 1 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done"}, done_cnt, d0 + 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_outs_zero("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // WRITE burst of two words
        begin_cmd();
        host_q.push_back(32'h57020010);
        host_q.push_back(32'h11111111);
        host_q.push_back(32'h22222222);
        wait_done("wr");
        chk("wr_nwe", wa_q.size(), 2);
        chk("wr_a0", wa_q[0], 16'h0010);
        chk("wr_d0", wd_q[0], 32'h11111111);
        chk("wr_a1", wa_q[1], 16'h0011);
        chk("wr_d1", wd_q[1], 32'h22222222);
        chk("wr_err", err_cnt - err0, 0);
        chk("wr_re", re_cnt - re0, 0);
        exp_q = '{32'hAC020010};
`ifdef AUX_CMD_CHECKSUM_EN
        exp_q.push_back(32'hAC020010);
`endif
        chk_rx("wr");

        // READ burst of three words
        begin_cmd();
        host_q.push_back(32'h52030100);
        wait_done("rd");
        chk("rd_nre", re_cnt - re0, 3);
        chk("rd_nwe", wa_q.size(), 0);
        chk("rd_err", err_cnt - err0, 0);
        exp_q = '{32'h52030100, 32'h000001A0, 32'h000001A1, 32'h000001A2};
`ifdef AUX_CMD_CHECKSUM_EN
        exp_q.push_back(32'h520300A3);
`endif
        chk_rx("rd");

        // Rejected: unknown opcode, then WRITE with zero count
        begin_cmd();
        host_q.push_back(32'h33000005);
        wait_done("rej_op");
        chk("rej_op_err", err_cnt - err0, 1);
        chk("rej_op_we", wa_q.size(), 0);
        chk("rej_op_re", re_cnt - re0, 0);
        exp_q = '{32'hEE000005};
`ifdef AUX_CMD_CHECKSUM_EN
        exp_q.push_back(32'hEE000005);
`endif
        chk_rx("rej_op");

        begin_cmd();
        host_q.push_back(32'h57000005);
        wait_done("rej_n0");
        chk("rej_n0_err", err_cnt - err0, 1);
        chk("rej_n0_we", wa_q.size(), 0);
        chk("rej_n0_re", re_cnt - re0, 0);
        exp_q = '{32'hEE000005};
`ifdef AUX_CMD_CHECKSUM_EN
        exp_q.push_back(32'hEE000005);
`endif
        chk_rx("rej_n0");

        // Address wrap with the bridge stalled between data words
        begin_cmd();
        host_q.push_back(32'h5702FFFF);
        host_q.push_back(32'hCAFE0001);
        n = 0;
        while (wa_q.size() < 1 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("wrap_first_we", wa_q.size(), 1);
        #1 hold = 1'b1;
        r0 = req_cnt;
        repeat (20) @(posedge clk);
        #1;
        chk("wrap_stall_noreq", req_cnt - r0, 0);
        hold = 1'b0;
        host_q.push_back(32'hCAFE0002);
        wait_done("wrap");
        chk("wrap_nwe", wa_q.size(), 2);
        chk("wrap_a0", wa_q[0], 16'hFFFF);
        chk("wrap_d0", wd_q[0], 32'hCAFE0001);
        chk("wrap_a1", wa_q[1], 16'h0000);
        chk("wrap_d1", wd_q[1], 32'hCAFE0002);
        exp_q = '{32'hAC02FFFF};
`ifdef AUX_CMD_CHECKSUM_EN
        exp_q.push_back(32'hAC02FFFF);
`endif
        chk_rx("wrap");

        // Single-word READ whose trailer, when enabled, is the XOR of echo and data
        begin_cmd();
        host_q.push_back(32'h52010000);
        wait_done("cs");
        exp_q = '{32'h52010000, 32'h0000F0F0};
`ifdef AUX_CMD_CHECKSUM_EN
        exp_q.push_back(32'h5201F0F0);
`endif
        chk_rx("cs");

        // Reset while waiting on register read data
        begin_cmd();
        host_q.push_back(32'h52020200);
        n = 0;
        while (re_cnt == re0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("mid_re", re_cnt - re0, 1);
        chk("mid_echo", rx_q.size() > 0 ? rx_q[0] : 32'h0, 32'h52020200);
        #1 reset = 1'b1;
        #1;
        chk_outs_zero("mid_rst");
        host_q.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("mid_nodone", done_cnt, d0);
        chk("mid_nore", re_cnt - re0, 1);
        @(posedge clk);
        #1 reset = 1'b0;

        begin_cmd();
        host_q.push_back(32'h57010020);
        host_q.push_back(32'h12345678);
        wait_done("post");
        chk("post_nwe", wa_q.size(), 1);
        chk("post_a0", wa_q[0], 16'h0020);
        chk("post_d0", wd_q[0], 32'h12345678);
        exp_q = '{32'hAC010020};
`ifdef AUX_CMD_CHECKSUM_EN
        exp_q.push_back(32'hAC010020);
`endif
        chk_rx("post");

        chk("proto_both_req", both_cnt, 0);
        chk("proto_req_when_busy", early_cnt, 0);
        chk("proto_req_in_stall", stall_req, 0);
        chk("proto_overlap", overlap_cnt, 0);
        chk("proto_dw_stable", dw_change, 0);
        chk("proto_err_alone", err_alone, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aux_cmd_engine.md
# aux_cmd_engine

FPGA-side command initiator for the host auxiliary channel. Drives the word-level control interface of the host-link bridge (`write_req` / `read_req` / `busy`): it pulls command words the host has written, decodes them, and performs burst accesses on a local register bus. It then pushes acknowledge and read-back words toward the host, giving the host a register-mapped view of the calibration logic over the pipe endpoints.

## Interface

Parameters:
- `REG_RD_LATENCY`, default 1: cycles from `reg_re` to valid `reg_rdata`; legal range 1–4.

Ports:
- `clk` in 1: sole clock, the same clock as the bridge control side.
- `reset` in 1: asynchronous, active-high.
- `aux_read_req` out 1: one-cycle pulse requesting one host word.
- `aux_write_req` out 1: one-cycle pulse sending `aux_data_write` to the host.
- `aux_data_write` out 32: word to the host; held stable from the request cycle until completion.
- `aux_data_read` in 32: host word; valid in the completion cycle of a read.
- `aux_address` out 17: constant 0.
- `aux_busy` in 1: bridge busy, which includes the request combinationally.
- `reg_addr` out 16: register address.
- `reg_wdata` out 32: register write data.
- `reg_we` out 1: one-cycle write strobe.
- `reg_re` out 1: one-cycle read strobe.
- `reg_rdata` in 32: read data, valid `REG_RD_LATENCY` cycles after `reg_re`.
- `cmd_done` out 1: one-cycle pulse when a command fully completes, including its response.
- `cmd_error` out 1: one-cycle pulse, coincident with `cmd_done`, for a rejected command.

## Operation

- Header word: bits [31:24] opcode, bits [23:16] count N, bits [15:0] start address A.
- WRITE, opcode 0x57:
  - N data words follow.
  - Word i is written to address (A+i) mod 2^16.
  - Response is one word: {8'hAC, N, A}.
- READ, opcode 0x52:
  - Response is the header echo {8'h52, N, A}, followed by N words read from (A+i) mod 2^16.
- Rejected commands: any other opcode, or N=0.
  - Response is {8'hEE, header[23:0]}.
  - No register access takes place.
  - `cmd_error` pulses.
- Bridge handshake:
  - A request is asserted only in a cycle where `aux_busy`=0.
  - Completion is the first later cycle with `aux_busy`=0.
  - Exactly one request is outstanding at a time.
  - Read and write requests are never asserted together.
- States and transitions:
  - IDLE: issues `aux_read_req` for the header → HDR_WAIT.
  - HDR_WAIT: on completion, latches the header → DECODE.
  - DECODE: WRITE → DAT_REQ; READ → ECHO; rejected → ERR.
  - DAT_REQ and DAT_WAIT: fetch one data word, then → REG_WR.
  - REG_WR: pulses `reg_we`, increments the index; if more words remain → DAT_REQ, else → ACK.
  - ECHO: sends the echo word → RD_REG.
  - RD_REG: pulses `reg_re` → RD_WAIT.
  - RD_WAIT: waits `REG_RD_LATENCY` cycles, captures `reg_rdata`, sends the word, then → RD_REG if words remain, else → FIN.
  - ACK and ERR: send the single response word → FIN.
  - FIN: after the optional checksum, pulses `cmd_done` → IDLE.
- Counters and arithmetic:
  - The word index is 8 bits and counts 0..N−1.
  - The address adder is 16 bits and wraps without a flag; A=0xFFFF with N=2 accesses 0xFFFF then 0x0000.
- The engine issues no requests while `aux_busy` is held high, including the period after reset while the bridge is itself in reset.
- A host that stalls mid-burst leaves the engine waiting indefinitely in DAT_WAIT; this is legal and there is no timeout.

## Timing

- Reset values:
  - All outputs are 0, and `aux_address`=0.
  - State is IDLE.
  - Header, index and checksum registers are 0.
- Reset mid-command abandons the command immediately:
  - No further strobes.
  - No `cmd_done`.
- Minimum per-word cost:
  - One request cycle plus the bridge latency, measured from the request to `aux_busy` low.
  - One cycle for `reg_we` on writes; 1+`REG_RD_LATENCY` cycles for `reg_re` and capture on reads.
- `reg_addr` and `reg_wdata` are registered and stable in the `reg_we` cycle. `reg_addr` is stable from `reg_re` through capture.
- `cmd_done` and `cmd_error` are asserted one cycle after the final write completion.

## Configuration

- `AUX_CMD_CHECKSUM_EN` defined:
  - A running XOR of every response word sent for the command (echo/ack/error word plus read data) is kept.
  - After the last response word, one extra word equal to that XOR is sent before `cmd_done`.
  - The XOR is cleared in IDLE.
- `AUX_CMD_CHECKSUM_EN` undefined: no trailer word and no checksum register.

## Test plan

- WRITE, checksum off: header 0x57020010, then 0x11111111 and 0x22222222.
  - Required: `reg_we` at 0x0010 with 0x11111111 and at 0x0011 with 0x22222222.
  - Host receives 0xAC020010; one `cmd_done` pulse, `cmd_error`=0.
- READ: header 0x52030100 with registers returning 0xA0+addr, `REG_RD_LATENCY`=1 and 3.
  - Host receives 0x52030100, 0x000001A0, 0x000001A1, 0x000001A2.
- Rejected commands: header 0x33000005 and header 0x57000005.
  - Each yields exactly one response word, {0xEE,header[23:0]}.
  - No `reg_we`/`reg_re`; `cmd_error` and `cmd_done` pulse together.
- Wrap and stall: WRITE header 0x5702FFFF, with `aux_busy` held high 20 cycles between the data words.
  - Writes go to 0xFFFF then 0x0000.
  - No request is issued while `aux_busy` is high.
- Checksum on: READ 0x52010000 with rdata 0x0000F0F0.
  - Trailer is 0x52010000^0x0000F0F0 = 0x5201F0F0.
- Reset asserted during RD_WAIT.
  - All outputs go to 0 asynchronously; no `cmd_done`.
  - A following header is processed normally.
